sump_cmd_ctrl: RTL and testbench
================================

Name: sump_cmd_ctrl

Overview:
Command controller between the UART receiver and the LogIP capture core.
- Consumes each completed SUMP command (opcode plus optional 32-bit argument) on its strobe.
- Decodes the command and updates the capture configuration registers.
- Arms and resets the core.
- Sequences the 4-byte ID reply to the UART transmitter over a valid/ack handshake.

Parameters:
STAGES, 4, number of trigger stages (1..4); each stage holds a 32-bit mask, value and config register.
CMD_WIDTH, 40, width of the command word from the receiver; fixed to 5 bytes.

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous reset, active-high
cmd_i  input  CMD_WIDTH  received command: [7:0] opcode (first byte); [39:8] argument, little-endian (byte 2 in [15:8]); [39:8] don't-care for short commands
stb_i  input  1  single-cycle pulse, cmd_i valid
done_i  input  1  capture core finished readout; clears armed
tx_data_o  output  8  byte to transmitter
tx_stb_o  output  1  tx_data_o valid; held until acknowledged
tx_ack_i  input  1  transmitter accepts byte when tx_stb_o && tx_ack_i
core_rst_o  output  1  one-cycle reset pulse to capture core
armed_o  output  1  capture armed (level)
trig_mask_o  output  STAGES*32  per-stage trigger masks; stage n at [32n+31:32n]
trig_val_o  output  STAGES*32  per-stage trigger values
trig_cfg_o  output  STAGES*32  per-stage trigger configs
div_o  output  24  sample clock divider
read_cnt_o  output  16  samples to read back
delay_cnt_o  output  16  samples after trigger
flags_o  output  32  flags register
drop_o  output  1  one-cycle pulse: command discarded because controller busy

Behaviour:
- Reset values: all config outputs 0, armed_o 0, tx_stb_o 0, tx_data_o 0x00, core_rst_o 0, drop_o 0. FSM is in IDLE.
- FSM states: IDLE, SEND.
- IDLE, stb_i=1: decode cmd_i[7:0]. Register and pulse effects appear on the next cycle (latency 1).
  - 0x00 RESET: core_rst_o pulses 1 cycle; armed_o cleared; config registers retained.
  - 0x01 RUN: armed_o set if clear; ignored if already armed.
  - 0x02 ID: go to SEND with byte index 0.
  - 0x11 / 0x13 (XON/XOFF): no effect.
  - 0xC0..0xCF trigger commands:
    - stage = opcode[3:2]; register select = opcode[1:0] (0 mask, 1 value, 2 config, 3 ignored).
    - stage >= STAGES is ignored.
    - Write full arg cmd_i[39:8].
  - 0x80: div_o <= arg[23:0].
  - 0x81: read_cnt_o <= arg[15:0]; delay_cnt_o <= arg[31:16].
  - 0x82: flags_o <= arg.
  - Any other opcode is ignored silently; drop_o stays 0.
- SEND:
  - Drives tx_stb_o=1, tx_data_o = ID byte[idx].
  - ID byte sequence: 0x31, 0x41, 0x4C, 0x53 ("1ALS").
  - On tx_ack_i, idx increments and the next byte appears on the following cycle.
  - tx_stb_o stays high between bytes unless the last byte was accepted.
  - After byte 3 is accepted: tx_stb_o=0, return to IDLE.
  - tx_data_o must not change while tx_stb_o && !tx_ack_i.
- stb_i while in SEND: command discarded, drop_o pulses next cycle, no state change.
- done_i: clears armed_o next cycle in any state.
  - done_i and RESET in the same cycle: armed cleared, core_rst_o pulses.
  - done_i and RUN in the same cycle while unarmed: RUN wins, armed_o=1.
  - done_i while armed, with RUN in the same cycle: armed cleared; RUN ignored.
- rst_i mid-SEND: on the next cycle tx_stb_o=0, idx=0, all outputs at reset values.
- Byte index is 2 bits and never wraps past 3 inside SEND.

Decomposition:
- Shared package logip_pkg:
  - opcode localparams (OP_RESET, OP_RUN, OP_ID, OP_XON, OP_XOFF, OP_TRIG_BASE, OP_DIV, OP_CNT, OP_FLAGS);
  - ID byte constants;
  - controller state enum ctrl_state_t.
- No sub-module required; the ID sequencer stays inline in the FSM.

Test Plan:
- Reset, then stb_i with opcode 0x02 and tx_ack_i tied 1 -> tx_data_o 0x31, 0x41, 0x4C, 0x53 on four consecutive cycles, tx_stb_o falls after the 4th byte.
- ID with tx_ack_i asserted only every 5th cycle -> tx_data_o stable while unacked; exactly 4 transfers.
- Second stb_i (0x01) during SEND -> drop_o pulse, armed_o stays 0, ID sequence completes.
- Long command 0xC4, arg 0xDEADBEEF -> trig_mask_o[63:32]=0xDEADBEEF, other stages 0.
- 0xC7 and 0xCC (with STAGES=3) -> no change.
- 0x81, arg 0x0010_0020 -> read_cnt_o=0x0020, delay_cnt_o=0x0010.
- 0x80, arg 0xFF123456 -> div_o=0x123456.
- RUN -> armed_o=1; second RUN -> no change; done_i -> armed_o=0.
- RESET -> core_rst_o single-cycle pulse, div_o retained.
- rst_i asserted mid-ID -> tx_stb_o=0 next cycle, all outputs 0.

Source files
------------

// File: rtl/logip_pkg.sv
// Shared definitions for the LogIP SUMP command path: opcodes, ID reply
// bytes and the command controller state type.
package logip_pkg;

  localparam logic [7:0] OP_RESET     = 8'h00;
  localparam logic [7:0] OP_RUN       = 8'h01;
  localparam logic [7:0] OP_ID        = 8'h02;
  localparam logic [7:0] OP_XON       = 8'h11;
  localparam logic [7:0] OP_XOFF      = 8'h13;
  localparam logic [7:0] OP_TRIG_BASE = 8'hC0;
  localparam logic [7:0] OP_DIV       = 8'h80;
  localparam logic [7:0] OP_CNT       = 8'h81;
  localparam logic [7:0] OP_FLAGS     = 8'h82;

  // ID reply "1ALS", sent first to last.
  localparam logic [7:0] ID_BYTE0 = 8'h31;
  localparam logic [7:0] ID_BYTE1 = 8'h41;
  localparam logic [7:0] ID_BYTE2 = 8'h4C;
  localparam logic [7:0] ID_BYTE3 = 8'h53;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ctrl_state_t;

  // Map a reply byte index to the ID byte sent at that position.
  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = ID_BYTE0;
      2'd1:    b = ID_BYTE1;
      2'd2:    b = ID_BYTE2;
      default: b = ID_BYTE3;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sump_cmd_ctrl.sv
// SUMP command controller: decodes commands from the UART receiver into the
// capture configuration, arms/resets the capture core and sends the ID reply.
module sump_cmd_ctrl
  import logip_pkg::*;
#(
  parameter int STAGES    = 4,
  parameter int CMD_WIDTH = 40
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [CMD_WIDTH-1:0]   cmd_i,
  input  logic                   stb_i,
  input  logic                   done_i,
  output logic [7:0]             tx_data_o,
  output logic                   tx_stb_o,
  input  logic                   tx_ack_i,
  output logic                   core_rst_o,
  output logic                   armed_o,
  output logic [STAGES*32-1:0]   trig_mask_o,
  output logic [STAGES*32-1:0]   trig_val_o,
  output logic [STAGES*32-1:0]   trig_cfg_o,
  output logic [23:0]            div_o,
  output logic [15:0]            read_cnt_o,
  output logic [15:0]            delay_cnt_o,
  output logic [31:0]            flags_o,
  output logic                   drop_o
);

  ctrl_state_t state_reg, state_next;
  logic [1:0]  idx_reg, idx_next;
  logic        armed_reg, armed_next;
  logic        core_rst_reg, core_rst_next;
  logic        drop_reg, drop_next;
  logic [23:0] div_reg;
  logic [15:0] read_cnt_reg;
  logic [15:0] delay_cnt_reg;
  logic [31:0] flags_reg;

  logic [7:0]  opcode;
  logic [31:0] arg;
  logic        cmd_ok;

  assign opcode = cmd_i[7:0];
  assign arg    = cmd_i[39:8];
  // Commands are only acted on while idle; in SEND they are dropped.
  assign cmd_ok = stb_i && (state_reg == IDLE);

  // State, reply index and single-cycle pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      idx_reg      <= 2'd0;
      armed_reg    <= 1'b0;
      core_rst_reg <= 1'b0;
      drop_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      armed_reg    <= armed_next;
      core_rst_reg <= core_rst_next;
      drop_reg     <= drop_next;
    end
  end

  // Next-state logic: command decode in IDLE, ID byte sequencing in SEND.
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    drop_next     = 1'b0;
    core_rst_next = 1'b0;
    // done_i clears armed in any state; a RUN below may still override it.
    armed_next    = armed_reg && !done_i;
    case (state_reg)
      IDLE: begin
        if (stb_i) begin
          if (opcode == OP_ID) begin
            state_next = SEND;
            idx_next   = 2'd0;
          end else if (opcode == OP_RESET) begin
            core_rst_next = 1'b1;
            armed_next    = 1'b0;
          end else if ((opcode == OP_RUN) && !armed_reg) begin
            armed_next = 1'b1;
          end
        end
      end
      SEND: begin
        if (stb_i) begin
          drop_next = 1'b1;
        end
        if (tx_ack_i) begin
          if (idx_reg == 2'd3) begin
            state_next = IDLE;
            idx_next   = 2'd0;
          end else begin
            idx_next = idx_reg + 2'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = 2'd0;
      end
    endcase
  end

  // Divider, count and flags registers written by their long commands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_reg       <= 24'd0;
      read_cnt_reg  <= 16'd0;
      delay_cnt_reg <= 16'd0;
      flags_reg     <= 32'd0;
    end else if (cmd_ok) begin
      case (opcode)
        OP_DIV: div_reg <= arg[23:0];
        OP_CNT: begin
          read_cnt_reg  <= arg[15:0];
          delay_cnt_reg <= arg[31:16];
        end
        OP_FLAGS: flags_reg <= arg;
        default: ;
      endcase
    end
  end

  // One register bank per implemented trigger stage; opcodes addressing a
  // stage that is not built simply match no bank.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [31:0] mask_reg, val_reg, cfg_reg;
    logic        hit;

    assign hit = cmd_ok && (opcode[7:4] == OP_TRIG_BASE[7:4]) &&
                 (opcode[3:2] == 2'(gi));

    // Stage register write; select 3 is reserved and ignored.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        mask_reg <= 32'd0;
        val_reg  <= 32'd0;
        cfg_reg  <= 32'd0;
      end else if (hit) begin
        case (opcode[1:0])
          2'd0:    mask_reg <= arg;
          2'd1:    val_reg  <= arg;
          2'd2:    cfg_reg  <= arg;
          default: ;
        endcase
      end
    end

    assign trig_mask_o[32*gi +: 32] = mask_reg;
    assign trig_val_o[32*gi +: 32]  = val_reg;
    assign trig_cfg_o[32*gi +: 32]  = cfg_reg;
  end

  // The reply byte comes straight from the index register, so it cannot
  // change while a byte waits for acknowledge.
  assign tx_stb_o    = (state_reg == SEND);
  assign tx_data_o   = (state_reg == SEND) ? id_byte(idx_reg) : 8'h00;
  assign core_rst_o  = core_rst_reg;
  assign armed_o     = armed_reg;
  assign drop_o      = drop_reg;
  assign div_o       = div_reg;
  assign read_cnt_o  = read_cnt_reg;
  assign delay_cnt_o = delay_cnt_reg;
  assign flags_o     = flags_reg;

endmodule

// File: tb/tb_sump_cmd_ctrl.sv
// Self-checking bench for sump_cmd_ctrl with three trigger stages: directed
// command sequences followed by random traffic, compared every cycle against
// a transaction-level model of the controller.
module tb_sump_cmd_ctrl;

  localparam int STAGES = 3;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b0;
  logic [39:0]          cmd_i = '0;
  logic                 stb_i = 1'b0;
  logic                 done_i = 1'b0;
  logic [7:0]           tx_data_o;
  logic                 tx_stb_o;
  logic                 tx_ack_i = 1'b0;
  logic                 core_rst_o;
  logic                 armed_o;
  logic [STAGES*32-1:0] trig_mask_o, trig_val_o, trig_cfg_o;
  logic [23:0]          div_o;
  logic [15:0]          read_cnt_o, delay_cnt_o;
  logic [31:0]          flags_o;
  logic                 drop_o;

  sump_cmd_ctrl #(.STAGES(STAGES), .CMD_WIDTH(40)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_i       (cmd_i),
    .stb_i       (stb_i),
    .done_i      (done_i),
    .tx_data_o   (tx_data_o),
    .tx_stb_o    (tx_stb_o),
    .tx_ack_i    (tx_ack_i),
    .core_rst_o  (core_rst_o),
    .armed_o     (armed_o),
    .trig_mask_o (trig_mask_o),
    .trig_val_o  (trig_val_o),
    .trig_cfg_o  (trig_cfg_o),
    .div_o       (div_o),
    .read_cnt_o  (read_cnt_o),
    .delay_cnt_o (delay_cnt_o),
    .flags_o     (flags_o),
    .drop_o      (drop_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int xfer_cnt = 0;

  // Reference model: what the outputs should show after the next edge.
  logic [7:0]  id_q[$];          // reply bytes still to be delivered
  logic        m_armed, m_core_rst, m_drop;
  logic [23:0] m_div;
  logic [15:0] m_read, m_delay;
  logic [31:0] m_flags;
  logic [31:0] m_mask[STAGES], m_val[STAGES], m_cfg[STAGES];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    id_q.delete();
    m_armed = 0; m_core_rst = 0; m_drop = 0;
    m_div = 0; m_read = 0; m_delay = 0; m_flags = 0;
    for (int s = 0; s < STAGES; s++) begin
      m_mask[s] = 0; m_val[s] = 0; m_cfg[s] = 0;
    end
  endtask

  task automatic compare_all();
    logic [STAGES*32-1:0] em, ev, ec;
    for (int s = 0; s < STAGES; s++) begin
      em[32*s +: 32] = m_mask[s];
      ev[32*s +: 32] = m_val[s];
      ec[32*s +: 32] = m_cfg[s];
    end
    check("tx_stb",   128'(tx_stb_o),    128'(id_q.size() != 0));
    check("tx_data",  128'(tx_data_o),   128'((id_q.size() != 0) ? id_q[0] : 8'h00));
    check("core_rst", 128'(core_rst_o),  128'(m_core_rst));
    check("armed",    128'(armed_o),     128'(m_armed));
    check("drop",     128'(drop_o),      128'(m_drop));
    check("div",      128'(div_o),       128'(m_div));
    check("read_cnt", 128'(read_cnt_o),  128'(m_read));
    check("delay",    128'(delay_cnt_o), 128'(m_delay));
    check("flags",    128'(flags_o),     128'(m_flags));
    check("mask",     128'(trig_mask_o), 128'(em));
    check("val",      128'(trig_val_o),  128'(ev));
    check("cfg",      128'(trig_cfg_o),  128'(ec));
  endtask

  // One clock of stimulus; the model advances from the command rules, then
  // every output is compared just after the edge.
  task automatic cycle(input logic stb, input logic [7:0] op, input logic [31:0] arg,
                       input logic done, input logic ack);
    logic busy;
    int   stage, sel;
    @(negedge clk_i);
    stb_i = stb; cmd_i = {arg, op}; done_i = done; tx_ack_i = ack;
    if (tx_stb_o && tx_ack_i) xfer_cnt++;
    busy = (id_q.size() != 0);
    m_core_rst = 0;
    m_drop = 0;
    if (stb)
      $display("cmd op=%02h arg=%08h busy=%0d done=%0d", op, arg, busy, done);
    if (busy) begin
      if (stb) m_drop = 1;
      if (ack) void'(id_q.pop_front());
      if (done) m_armed = 0;
    end else if (stb && op == 8'h01 && !m_armed) begin
      m_armed = 1;                       // RUN from unarmed beats done_i
    end else begin
      if (done) m_armed = 0;
      if (stb) begin
        stage = int'(op[3:2]);
        sel   = int'(op[1:0]);
        if (op == 8'h00) begin
          m_core_rst = 1;
          m_armed = 0;
        end else if (op == 8'h02) begin
          id_q = '{8'h31, 8'h41, 8'h4C, 8'h53};
        end else if (op == 8'h80) m_div = arg[23:0];
        else if (op == 8'h81) begin
          m_read = arg[15:0];
          m_delay = arg[31:16];
        end else if (op == 8'h82) m_flags = arg;
        else if (op[7:4] == 4'hC && stage < STAGES) begin
          if (sel == 0) m_mask[stage] = arg;
          else if (sel == 1) m_val[stage] = arg;
          else if (sel == 2) m_cfg[stage] = arg;
        end
      end
    end
    @(posedge clk_i);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input logic ack);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 32'h0, 1'b0, ack);
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    rst_i = 1; stb_i = 0; done_i = 0; tx_ack_i = 0; cmd_i = '0;
    model_clear();
    $display("reset");
    @(posedge clk_i);
    #1;
    compare_all();
    @(negedge clk_i);
    rst_i = 0;
  endtask

  initial begin
    logic [7:0] op;
    model_clear();
    apply_reset();

    // ID reply with ack held high: four consecutive bytes then stb drops.
    cycle(1, 8'h02, 32'h0, 0, 0);
    idle(5, 1'b1);

    // ID reply with ack every 5th cycle: data holds, exactly four transfers.
    xfer_cnt = 0;
    cycle(1, 8'h02, 32'h0, 0, 0);
    for (int i = 0; i < 22; i++) cycle(0, 8'h00, 32'h0, 0, (i % 5) == 4);
    check("xfer_cnt", 128'(xfer_cnt), 128'(4));

    // RUN during SEND is dropped; reply still completes.
    cycle(1, 8'h02, 32'h0, 0, 0);
    cycle(1, 8'h01, 32'h0, 0, 0);
    idle(5, 1'b1);

    // Trigger writes, including reserved select and a missing stage.
    cycle(1, 8'hC4, 32'hDEADBEEF, 0, 0);
    cycle(1, 8'hC7, 32'h12345678, 0, 0);
    cycle(1, 8'hCC, 32'hCAFEF00D, 0, 0);
    cycle(1, 8'hC9, 32'h0BADF00D, 0, 0);
    cycle(1, 8'h81, 32'h0010_0020, 0, 0);
    cycle(1, 8'h80, 32'hFF123456, 0, 0);
    cycle(1, 8'h82, 32'hA5A5_0F0F, 0, 0);

    // Arming, re-arming, done, and the done/RUN/RESET collisions.
    cycle(1, 8'h01, 32'h0, 0, 0);
    cycle(1, 8'h01, 32'h0, 0, 0);
    cycle(0, 8'h00, 32'h0, 1, 0);
    cycle(1, 8'h01, 32'h0, 1, 0);
    cycle(1, 8'h01, 32'h0, 1, 0);
    cycle(1, 8'h01, 32'h0, 0, 0);
    cycle(1, 8'h00, 32'h0, 1, 0);
    cycle(1, 8'h00, 32'h0, 0, 0);
    idle(2, 1'b0);

    // Reset in the middle of an ID reply.
    cycle(1, 8'h02, 32'h0, 0, 0);
    cycle(0, 8'h00, 32'h0, 0, 1);
    apply_reset();
    idle(2, 1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0: op = 8'h00;
        1: op = 8'h01;
        2: op = 8'h02;
        3: op = 8'h80;
        4: op = 8'h81;
        5: op = 8'h82;
        6, 7: op = 8'hC0 | 8'($urandom_range(0, 15));
        8: op = ($urandom_range(0, 1) != 0) ? 8'h11 : 8'h13;
        default: op = 8'($urandom);
      endcase
      cycle($urandom_range(0, 3) == 0, op, $urandom,
            $urandom_range(0, 15) == 0, $urandom_range(0, 1) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
